bcd_display_scanner: RTL and testbench

//   Time-multiplexed controller that shares one BCD-to-7-segment decoder across
//   NUM_DIGITS common-cathode digits. Accepts a packed BCD word over a

---
 rtl/bcd_display_scanner_pkg.sv | 18 +
 rtl/bcd_display_scanner_if.sv | 21 ++
 rtl/bcd_display_scanner_seg_decode.sv | 16 +
 rtl/bcd_display_scanner.sv | 165 ++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and segment patterns for the BCD display scanner.
// Segment order is {A,B,C,D,E,F,G}, active-high.
package bcd_display_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h01;

  localparam logic [6:0] SEG_PATTERN [10] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Load handshake bundle for the BCD display scanner.
// The master offers a packed BCD word; the slave accepts it.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/bcd_display_scanner_seg_decode.sv
// Combinational BCD to 7-segment decoder.
// Codes above 9 show a dash.
module bcd_seg_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Table lookup for valid BCD, dash otherwise
  always_comb begin
    o_seg = SEG_DASH;
    if (i_code < 4'd10) o_seg = SEG_PATTERN[i_code];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner with frame-aligned
// word commit, guard gaps and leading-zero blanking.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lzb_en,
  bcd_display_scanner_if.slave  load_if,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_tick
);

  localparam int MAXC = (REFRESH_DIV > GUARD_CYCLES) ?
                        REFRESH_DIV : GUARD_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [DW-1:0]         r_display;
  logic [DW-1:0]         r_pending;
  logic                  r_pend_full;
  logic                  r_tick;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_den;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_den_nxt;
  logic                  w_last;
  logic                  w_commit;
  logic                  w_xfer;
  logic                  w_enter_drive;
  logic                  w_stay_drive;
  logic [3:0]            w_code;
  logic [6:0]            w_dec_seg;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_blank;

  assign w_last = (r_state == ST_GUARD) ? (r_cnt == GUARD_LAST)
                                        : (r_cnt == DRIVE_LAST);
  assign w_commit = enable && (r_state == ST_DRIVE)
                    && w_last && (r_idx == IDX_LAST);
  assign w_enter_drive = enable && (r_state == ST_GUARD) && w_last;
  assign w_stay_drive  = enable && (r_state == ST_DRIVE) && !w_last;
  assign w_xfer = load_if.load_valid && !r_pend_full;
  assign load_if.load_ready = !r_pend_full;

  assign w_code = r_display[{r_idx, 2'b00} +: 4];

  bcd_seg_decode u_dec (
    .i_code (w_code),
    .o_seg  (w_dec_seg)
  );

  // Digit i>0 is a leading zero if it and all higher digits are 0
  always_comb begin
    logic w_run;
    w_run = 1'b1;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_run = w_run & (r_display[4*i +: 4] == 4'd0);
      w_lz_mask[i] = w_run;
    end
  end

  assign w_blank = lzb_en && w_lz_mask[r_idx];

  // FSM state, slot counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GUARD;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: disable parks in GUARD(0), else advance on slot end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    if (!enable) begin
      w_state_nxt = ST_GUARD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else if (w_last) begin
      w_cnt_nxt = '0;
      unique case (r_state)
        ST_GUARD: w_state_nxt = ST_DRIVE;
        ST_DRIVE: begin
          w_state_nxt = ST_GUARD;
          w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        default: w_state_nxt = ST_GUARD;
      endcase
    end
  end

  // Pin values for the next cycle, latched at DRIVE entry
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_den_nxt = '0;
    if (w_enter_drive && !w_blank) begin
      w_seg_nxt = w_dec_seg;
      w_den_nxt = NUM_DIGITS'(1) << r_idx;
    end else if (w_stay_drive) begin
      w_seg_nxt = r_seg;
      w_den_nxt = r_den;
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_den <= '0;
    end else begin
      r_seg <= w_seg_nxt;
      r_den <= w_den_nxt;
    end
  end

  // Pending slot and frame-aligned commit into the display word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display   <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_tick <= w_commit;
      if (w_commit && r_pend_full) begin
        r_display   <= r_pending;
        r_pend_full <= 1'b0;
      end
      if (w_xfer) begin
        r_pending   <= load_if.load_data;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign digit_en   = r_den;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner:
// expected slots are queued at load time and popped per frame.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          lzb_en = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] digit_en;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ND-1:0] den;
    logic [6:0]    seg;
  } slot_t;

  slot_t exp_q[$];

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) lif ();

  bcd_display_scanner #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lzb_en     (lzb_en),
    .load_if    (lif.slave),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_pat(input logic [3:0] d);
    case (d)
      4'd0: ref_pat = 7'b1111110;
      4'd1: ref_pat = 7'b0110000;
      4'd2: ref_pat = 7'b1101101;
      4'd3: ref_pat = 7'b1111001;
      4'd4: ref_pat = 7'b0110011;
      4'd5: ref_pat = 7'b1011011;
      4'd6: ref_pat = 7'b1011111;
      4'd7: ref_pat = 7'b1110000;
      4'd8: ref_pat = 7'b1111111;
      4'd9: ref_pat = 7'b1111011;
      default: ref_pat = 7'b0000001;
    endcase
  endfunction

  task automatic push_word(input logic [15:0] w, input logic lz);
    slot_t e;
    logic [15:0] hi;
    for (int i = 0; i < ND; i++) begin
      hi = w >> (4 * i);
      if (lz && i > 0 && hi == 16'd0) begin
        e.den = '0;
        e.seg = '0;
      end else begin
        e.den = ND'(1) << i;
        e.seg = ref_pat(w[4*i +: 4]);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    int n = 0;
    while (lif.load_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lif.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_wait: load_ready=%b required 1", lif.load_ready);
    end
    lif.load_valid = 1'b1;
    lif.load_data  = w;
    @(posedge clk);
    #1;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'($urandom);
    push_word(w, lzb_en);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_full: load_ready=%b required 0", lif.load_ready);
    end
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s: frame_tick=%b after %0d cycles, required 1",
               name, frame_tick, n);
    end
  endtask

  task automatic check_frame(input string name);
    slot_t e;
    for (int s = 0; s < ND; s++) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL %s: scoreboard empty at slot %0d", name, s);
        return;
      end
      e = exp_q.pop_front();
      for (int c = 0; c < RD; c++) begin
        @(negedge clk);
        checks++;
        if ({digit_en, seg, frame_tick} !== {e.den, e.seg, 1'b0}) begin
          errors++;
          $display("FAIL %s slot%0d cyc%0d: got den=%b seg=%b tick=%b required den=%b seg=%b tick=0",
                   name, s, c, digit_en, seg, frame_tick, e.den, e.seg);
        end
      end
      @(negedge clk);
      checks++;
      if ({digit_en, seg, frame_tick} !== {4'b0, 7'b0, (s == ND - 1)}) begin
        errors++;
        $display("FAIL %s guard%0d: got den=%b seg=%b tick=%b required den=0000 seg=0000000 tick=%0d",
                 name, s, digit_en, seg, frame_tick, (s == ND - 1));
      end
    end
  endtask

  task automatic test_reset;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 7'b0) begin
      errors++;
      $display("FAIL rst_seg: got %b required 0000000", seg);
    end
    checks++;
    if (digit_en !== 4'b0) begin
      errors++;
      $display("FAIL rst_den: got %b required 0000", digit_en);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick: got %b required 0", frame_tick);
    end
    checks++;
    if (lif.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b required 1", lif.load_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001 || seg !== 7'b1111110) begin
      errors++;
      $display("FAIL rst_first_drive: got den=%b seg=%b required den=0001 seg=1111110",
               digit_en, seg);
    end
  endtask

  task automatic test_load;
    load_word(16'h1234);
    wait_tick("load_tick");
    check_frame("load_1234");
  endtask

  task automatic test_decode;
    logic [15:0] words [2];
    words[0] = 16'h5678;
    words[1] = 16'h90CF;
    for (int k = 0; k < 2; k++) begin
      load_word(words[k]);
      wait_tick("dec_tick");
      check_frame("decode");
    end
  endtask

  task automatic test_lzb;
    logic [15:0] words [3];
    words[0] = 16'h0050;
    words[1] = 16'h0000;
    words[2] = 16'h00A0;
    lzb_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_word(words[k]);
      wait_tick("lzb_tick");
      check_frame("lzb");
    end
    lzb_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    load_word(16'h2468);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1357;
    @(negedge clk);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_blocked: load_ready=%b required 0", lif.load_ready);
    end
    wait_tick("bp_tick");
    checks++;
    if (lif.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_freed: load_ready=%b required 1", lif.load_ready);
    end
    @(posedge clk);
    #1;
    lif.load_valid = 1'b0;
    push_word(16'h1357, lzb_en);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_taken: load_ready=%b required 0", lif.load_ready);
    end
    check_frame("bp_first");
    check_frame("bp_second");
  endtask

  task automatic test_enable;
    logic ok;
    repeat (12) @(negedge clk);
    checks++;
    if (digit_en !== 4'b0100 || seg !== 7'b1111001) begin
      errors++;
      $display("FAIL en_mid_drive2: got den=%b seg=%b required den=0100 seg=1111001",
               digit_en, seg);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0 || seg !== 7'b0) begin
      errors++;
      $display("FAIL en_dark: got den=%b seg=%b required 0000/0000000",
               digit_en, seg);
    end
    load_word(16'h0987);
    ok = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (digit_en !== 4'b0 || seg !== 7'b0 || frame_tick !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_held: activity while disabled, got ok=%b required 1", ok);
    end
    checks++;
    if (lif.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL en_deferred: load_ready=%b required 0", lif.load_ready);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001 || seg !== 7'b1110000) begin
      errors++;
      $display("FAIL en_resume: got den=%b seg=%b required den=0001 seg=1110000",
               digit_en, seg);
    end
    wait_tick("en_tick");
    check_frame("en_frame");
  endtask

  task automatic test_async_reset;
    load_word(16'h4321);
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001 || seg !== 7'b1110000) begin
      errors++;
      $display("FAIL ar_pre: got den=%b seg=%b required den=0001 seg=1110000",
               digit_en, seg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digit_en, seg, frame_tick} !== 12'b0) begin
      errors++;
      $display("FAIL ar_clear: got den=%b seg=%b tick=%b required all 0",
               digit_en, seg, frame_tick);
    end
    checks++;
    if (lif.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_ready: got %b required 1", lif.load_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_en !== 4'b0001 || seg !== 7'b1111110) begin
      errors++;
      $display("FAIL ar_restart: got den=%b seg=%b required den=0001 seg=1111110",
               digit_en, seg);
    end
    push_word(16'h0000, lzb_en);
    wait_tick("ar_tick");
    check_frame("ar_pending_lost");
  endtask

  initial begin
    test_reset();
    test_load();
    test_decode();
    test_lzb();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
